// File: rtl/onchip_mem_pkg.sv
// Shared definitions for the dual-port on-chip memory slice.
//   clr_state_e : power-up clear sequencer states
//   byte_lanes  : number of 8-bit lanes in a data word
//   CLOG2       : bits needed to count 0..v-1 (minimum 1)
package onchip_mem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_e;

    function automatic int unsigned byte_lanes(input int unsigned dw);
        return dw / 8;
    endfunction

    function automatic int unsigned CLOG2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((r < 31) && ((32'd1 << r) < v)) r = r + 1;
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/onchip_mem_dp_if.sv
// Avalon-MM slave port bundle for onchip_mem_dp (one instance per port).
//   address/byteenable/chipselect/clken/read/write/writedata : master -> slave
//   readdata/readdatavalid/waitrequest                       : slave -> master
interface onchip_mem_dp_if
    import onchip_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]                 address;
    logic [byte_lanes(DATA_WIDTH)-1:0]     byteenable;
    logic                                  chipselect;
    logic                                  clken;
    logic                                  read;
    logic                                  write;
    logic [DATA_WIDTH-1:0]                 writedata;
    logic [DATA_WIDTH-1:0]                 readdata;
    logic                                  readdatavalid;
    logic                                  waitrequest;

    modport master (
        output address, byteenable, chipselect, clken, read, write, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, byteenable, chipselect, clken, read, write, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/onchip_mem_dp_bank.sv
// Storage array with two independent synchronous read/write ports.
//   clk          : clock
//   we1/we2      : per-byte-lane write enables (port 1 / port 2)
//   addr1/addr2  : word addresses, must be < DEPTH when enabled
//   wdata1/2     : write data
//   re1/re2      : read enables; rdata1/2 update only on an enabled read
// Same-address writes: lanes enabled on both ports take port-1 data.
// Read during write to the same word from the other port returns old data.
module onchip_mem_dp_bank
    import onchip_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 7680,
    parameter int unsigned ADDR_WIDTH = 13
)
(
    input  logic                              clk,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] we1,
    input  logic [ADDR_WIDTH-1:0]             addr1,
    input  logic [DATA_WIDTH-1:0]             wdata1,
    input  logic                              re1,
    output logic [DATA_WIDTH-1:0]             rdata1,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] we2,
    input  logic [ADDR_WIDTH-1:0]             addr2,
    input  logic [DATA_WIDTH-1:0]             wdata2,
    input  logic                              re2,
    output logic [DATA_WIDTH-1:0]             rdata2
);
    localparam int unsigned NB = byte_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Port 2 lanes are scheduled first so a colliding port-1 lane write
    // overrides it; reads sample the pre-edge contents (old data).
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NB; b++) begin
            if (we2[b]) mem[addr2][b*8 +: 8] <= wdata2[b*8 +: 8];
            if (we1[b]) mem[addr1][b*8 +: 8] <= wdata1[b*8 +: 8];
        end
        if (re1) rdata1 <= mem[addr1];
        if (re2) rdata2 <= mem[addr2];
    end
endmodule

// File: rtl/onchip_mem_dp.sv
// True-dual-port on-chip memory with two Avalon-MM slave ports.
//   clk, reset : single clock, asynchronous active-high reset
//   s1, s2     : onchip_mem_dp_if slave ports (see interface for signals)
// Holds the power-up clear sequencer, address range checks, clken gating
// and the per-port readdatavalid / output pipelines.
module onchip_mem_dp
    import onchip_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned DEPTH          = 7680,
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned OUTPUT_REG     = 0,
    parameter int unsigned CLEAR_ON_RESET = 1
)
(
    input  logic           clk,
    input  logic           reset,
    onchip_mem_dp_if.slave s1,
    onchip_mem_dp_if.slave s2
);
    localparam int unsigned NB = byte_lanes(DATA_WIDTH);
    localparam int unsigned CW = CLOG2(DEPTH);

    clr_state_e    state;
    logic [CW-1:0] clr_addr;
    logic          busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_addr <= '0;
        end else if (state == CLEAR) begin
            if (clr_addr == CW'(DEPTH - 1)) state <= READY;
            else                            clr_addr <= clr_addr + CW'(1);
        end
    end

    assign busy           = (state == CLEAR);
    assign s1.waitrequest = busy | ~s1.clken;
    assign s2.waitrequest = busy | ~s2.clken;

    logic [1:0] clken, acc_rd, acc_wr, in_rng;

    assign clken     = {s2.clken, s1.clken};
    assign acc_wr[0] = s1.chipselect & s1.write & s1.clken & ~s1.waitrequest;
    assign acc_wr[1] = s2.chipselect & s2.write & s2.clken & ~s2.waitrequest;
    // A simultaneous read+write on one port performs only the write.
    assign acc_rd[0] = s1.chipselect & s1.read & ~s1.write & s1.clken & ~s1.waitrequest;
    assign acc_rd[1] = s2.chipselect & s2.read & ~s2.write & s2.clken & ~s2.waitrequest;
    assign in_rng[0] = (32'(s1.address) < DEPTH);
    assign in_rng[1] = (32'(s2.address) < DEPTH);

    // Port 1 of the bank doubles as the clear write path.
    logic [NB-1:0]         we1, we2;
    logic [ADDR_WIDTH-1:0] a1;
    logic [DATA_WIDTH-1:0] wd1, rd1, rd2;

    assign we1 = busy ? '1 : ((acc_wr[0] & in_rng[0]) ? s1.byteenable : '0);
    assign a1  = busy ? ADDR_WIDTH'(clr_addr) : s1.address;
    assign wd1 = busy ? '0 : s1.writedata;
    assign we2 = (acc_wr[1] & in_rng[1]) ? s2.byteenable : '0;

    onchip_mem_dp_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clk    (clk),
        .we1    (we1),
        .addr1  (a1),
        .wdata1 (wd1),
        .re1    (acc_rd[0] & in_rng[0]),
        .rdata1 (rd1),
        .we2    (we2),
        .addr2  (s2.address),
        .wdata2 (s2.writedata),
        .re2    (acc_rd[1] & in_rng[1]),
        .rdata2 (rd2)
    );

    // Stage 1: v1 marks a read result, z1 forces zero data. z1 resets to 1
    // so readdata is zero after reset even though the array has no reset.
    logic [1:0]            v1, z1;
    logic [DATA_WIDTH-1:0] d1 [2];

    assign d1[0] = z1[0] ? '0 : rd1;
    assign d1[1] = z1[1] ? '0 : rd2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= '0;
            z1 <= '1;
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                if (clken[p]) begin
                    v1[p] <= acc_rd[p];
                    if (acc_rd[p]) z1[p] <= ~in_rng[p];
                end
            end
        end
    end

    // Valid is masked by clken: a result held across a stall is presented
    // in the first enabled cycle and retired by that cycle's edge.
    if (OUTPUT_REG != 0) begin : g_oreg
        logic [1:0]            v2;
        logic [DATA_WIDTH-1:0] d2 [2];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                v2    <= '0;
                d2[0] <= '0;
                d2[1] <= '0;
            end else begin
                for (int unsigned p = 0; p < 2; p++) begin
                    if (clken[p]) begin
                        v2[p] <= v1[p];
                        if (v1[p]) d2[p] <= d1[p];
                    end
                end
            end
        end

        assign s1.readdatavalid = v2[0] & clken[0];
        assign s2.readdatavalid = v2[1] & clken[1];
        assign s1.readdata      = d2[0];
        assign s2.readdata      = d2[1];
    end else begin : g_noreg
        assign s1.readdatavalid = v1[0] & clken[0];
        assign s2.readdatavalid = v1[1] & clken[1];
        assign s1.readdata      = d1[0];
        assign s2.readdata      = d1[1];
    end
endmodule
